// File: rtl/rx_frame_dispatcher_pkg.sv
// rx_frame_dispatcher shared types
// Ethernet header constants and dispatcher state encoding.
package rx_frame_dispatcher_pkg;

  localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;
  localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
  localparam int          ETH_HDR_LEN  = 14;
  localparam logic [47:0] MAC_BCAST    = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ROUTE_IP,
    ST_ROUTE_ARP,
    ST_DROP
  } disp_state_t;

  typedef struct packed {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] etype;
  } eth_hdr_t;

endpackage

// File: rtl/rx_frame_dispatcher_if.sv
// rx_frame_dispatcher sink bus
// Payload streams to the IP and ARP handlers plus their busy flags.
interface rx_frame_dispatcher_if;

  logic [7:0] ip_data;
  logic       ip_en;
  logic       ip_sop;
  logic       ip_eop;
  logic       ip_busy;
  logic [7:0] arp_data;
  logic       arp_en;
  logic       arp_sop;
  logic       arp_eop;
  logic       arp_busy;

  modport master (
    output ip_data, ip_en, ip_sop, ip_eop,
    output arp_data, arp_en, arp_sop, arp_eop,
    input  ip_busy, arp_busy
  );

  modport slave (
    input  ip_data, ip_en, ip_sop, ip_eop,
    input  arp_data, arp_en, arp_sop, arp_eop,
    output ip_busy, arp_busy
  );

endinterface

// File: rtl/rx_frame_dispatcher_eth_hdr_capture.sv
// eth_hdr_capture: header byte counter and field registers
// hdr is valid together with dec, on the cycle byte 13 is on datain.
module eth_hdr_capture
  import rx_frame_dispatcher_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] datain,
  input  logic       data_en,
  input  logic       sof,
  output eth_hdr_t   hdr,
  output logic       dec
);

  localparam logic [3:0] HLEN  = 4'(ETH_HDR_LEN);
  localparam logic [3:0] HLAST = 4'(ETH_HDR_LEN - 1);

  logic [3:0]   idx;
  logic [103:0] sr;

  // idx stays 0 until sof, so untracked bytes never shift in
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx <= 4'd0;
      sr  <= '0;
    end else if (sof) begin
      idx <= 4'd1;
      sr  <= {sr[95:0], datain};
    end else if (!data_en) begin
      idx <= 4'd0;
    end else if (idx != 4'd0 && idx < HLEN) begin
      idx <= idx + 4'd1;
      sr  <= {sr[95:0], datain};
    end
  end

  assign hdr = {sr, datain};
  assign dec = data_en && (idx == HLAST);

endmodule

// File: rtl/rx_frame_dispatcher.sv
// rx_frame_dispatcher: Ethernet RX header filter and payload steering
// Routes frames to the IP or ARP sink and keeps per-class counters.
module rx_frame_dispatcher
  import rx_frame_dispatcher_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h0200_0000_0001,
  parameter bit          PROMISC   = 1'b0,
  parameter int          CNT_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [7:0]           datain,
  input  logic                 data_en,
  rx_frame_dispatcher_if.master sink,
  output logic [47:0]          pc_mac,
  output logic [CNT_W-1:0]     cnt_ip,
  output logic [CNT_W-1:0]     cnt_arp,
  output logic [CNT_W-1:0]     cnt_drop
);

  disp_state_t state, state_n;
  eth_hdr_t    hdr;
  logic        dec, sof;
  logic        en_q, first, first_n;
  logic        match, ip_ok, arp_ok;
  logic        ip_en_n, ip_sop_n, ip_eop_n;
  logic        arp_en_n, arp_sop_n, arp_eop_n;
  logic        inc_ip, inc_arp, inc_drop, load_mac;

  eth_hdr_capture u_hdr (
    .clock   (clock),
    .reset_n (reset_n),
    .datain  (datain),
    .data_en (data_en),
    .sof     (sof),
    .hdr     (hdr),
    .dec     (dec)
  );

  assign match = (hdr.dest == BOARD_MAC) || PROMISC ||
                 (hdr.dest == MAC_BCAST &&
                  hdr.etype == ETH_TYPE_ARP);
  assign ip_ok  = match && hdr.etype == ETH_TYPE_IP &&
                  !sink.ip_busy;
  assign arp_ok = match && hdr.etype == ETH_TYPE_ARP &&
                  !sink.arp_busy;

  // en_q resets high: a frame cut by reset is ignored until data_en drops
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      first <= 1'b0;
      en_q  <= 1'b1;
    end else begin
      state <= state_n;
      first <= first_n;
      en_q  <= data_en;
    end
  end

  always_comb begin
    state_n   = state;
    first_n   = first;
    sof       = 1'b0;
    ip_en_n   = 1'b0;
    ip_sop_n  = 1'b0;
    ip_eop_n  = 1'b0;
    arp_en_n  = 1'b0;
    arp_sop_n = 1'b0;
    arp_eop_n = 1'b0;
    inc_ip    = 1'b0;
    inc_arp   = 1'b0;
    inc_drop  = 1'b0;
    load_mac  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (data_en && !en_q) begin
          sof     = 1'b1;
          state_n = ST_HDR;
        end
      end
      ST_HDR: begin
        if (!data_en) begin
          inc_drop = 1'b1;
          state_n  = ST_IDLE;
        end else if (dec) begin
          unique case (1'b1)
            ip_ok: begin
              state_n  = ST_ROUTE_IP;
              load_mac = 1'b1;
              first_n  = 1'b1;
            end
            arp_ok: begin
              state_n  = ST_ROUTE_ARP;
              load_mac = 1'b1;
              first_n  = 1'b1;
            end
            default: state_n = ST_DROP;
          endcase
        end
      end
      ST_ROUTE_IP: begin
        if (data_en) begin
          ip_en_n  = 1'b1;
          ip_sop_n = first;
          first_n  = 1'b0;
        end else begin
          ip_eop_n = 1'b1;
          inc_ip   = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      ST_ROUTE_ARP: begin
        if (data_en) begin
          arp_en_n  = 1'b1;
          arp_sop_n = first;
          first_n   = 1'b0;
        end else begin
          arp_eop_n = 1'b1;
          inc_arp   = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!data_en) begin
          inc_drop = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sink.ip_data  <= 8'h00;
      sink.ip_en    <= 1'b0;
      sink.ip_sop   <= 1'b0;
      sink.ip_eop   <= 1'b0;
      sink.arp_data <= 8'h00;
      sink.arp_en   <= 1'b0;
      sink.arp_sop  <= 1'b0;
      sink.arp_eop  <= 1'b0;
      pc_mac        <= 48'h0;
      cnt_ip        <= '0;
      cnt_arp       <= '0;
      cnt_drop      <= '0;
    end else begin
      sink.ip_data  <= ip_en_n ? datain : 8'h00;
      sink.ip_en    <= ip_en_n;
      sink.ip_sop   <= ip_sop_n;
      sink.ip_eop   <= ip_eop_n;
      sink.arp_data <= arp_en_n ? datain : 8'h00;
      sink.arp_en   <= arp_en_n;
      sink.arp_sop  <= arp_sop_n;
      sink.arp_eop  <= arp_eop_n;
      if (load_mac) pc_mac <= hdr.src;
      if (inc_ip)   cnt_ip   <= cnt_ip + CNT_W'(1);
      if (inc_arp)  cnt_arp  <= cnt_arp + CNT_W'(1);
      if (inc_drop) cnt_drop <= cnt_drop + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rx_frame_dispatcher.sv
// tb_rx_frame_dispatcher: table-driven frames with payload scoreboard
// A second instance runs with PROMISC=1 on the same byte stream.
module tb_rx_frame_dispatcher;

  localparam logic [47:0] BM = 48'h0200_0000_0001;
  localparam logic [47:0] OM = 48'h0200_0000_0002;
  localparam logic [47:0] BC = 48'hFFFF_FFFF_FFFF;

  typedef struct {
    logic [47:0] dest;
    logic [47:0] src;
    logic [15:0] etype;
    int          len;
    int          ib_lo, ib_hi;
    int          ab_lo, ab_hi;
    int          exp;
    int          expp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  datain = 8'h00;
  logic        data_en = 1'b0;
  logic [47:0] pc_mac0, pc_mac1;
  logic [15:0] cnt_ip0, cnt_arp0, cnt_drop0;
  logic [15:0] cnt_ip1, cnt_arp1, cnt_drop1;

  rx_frame_dispatcher_if sif0();
  rx_frame_dispatcher_if sif1();

  rx_frame_dispatcher #(.PROMISC(1'b0)) dut0 (
    .clock(clk), .reset_n(reset_n),
    .datain(datain), .data_en(data_en),
    .sink(sif0), .pc_mac(pc_mac0),
    .cnt_ip(cnt_ip0), .cnt_arp(cnt_arp0),
    .cnt_drop(cnt_drop0)
  );

  rx_frame_dispatcher #(.PROMISC(1'b1)) dut1 (
    .clock(clk), .reset_n(reset_n),
    .datain(datain), .data_en(data_en),
    .sink(sif1), .pc_mac(pc_mac1),
    .cnt_ip(cnt_ip1), .cnt_arp(cnt_arp1),
    .cnt_drop(cnt_drop1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m0_ip = 0, m0_arp = 0, m0_drop = 0;
  int m1_ip = 0, m1_arp = 0, m1_drop = 0;
  logic [47:0] pc0 = '0, pc1 = '0;
  int e_ip_eop = 0, e_arp_eop = 0;
  int ip_eops = 0, arp_eops = 0;
  logic [8:0] q_ip[$];
  logic [8:0] q_arp[$];
  logic [8:0] pe;
  vec_t tbl[11];

  function automatic void chk(string name,
                              logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endfunction

  // payload scoreboard on dut0's sinks: {sop, data}
  always @(negedge clk) begin
    if (sif0.ip_en || sif0.arp_en)
      chk("sink_excl", 64'(sif0.ip_en & sif0.arp_en), 0);
    if (sif0.ip_en) begin
      chk("ip_pending", 64'(q_ip.size() > 0), 1);
      if (q_ip.size() > 0) begin
        pe = q_ip.pop_front();
        chk("ip_byte", {sif0.ip_sop, sif0.ip_data}, pe);
      end
    end
    if (sif0.ip_sop) chk("ip_sop_en", 64'(sif0.ip_en), 1);
    if (sif0.ip_eop) begin
      ip_eops++;
      chk("ip_eop_drained", q_ip.size(), 0);
    end
    if (sif0.arp_en) begin
      chk("arp_pending", 64'(q_arp.size() > 0), 1);
      if (q_arp.size() > 0) begin
        pe = q_arp.pop_front();
        chk("arp_byte", {sif0.arp_sop, sif0.arp_data}, pe);
      end
    end
    if (sif0.arp_sop) chk("arp_sop_en", 64'(sif0.arp_en), 1);
    if (sif0.arp_eop) begin
      arp_eops++;
      chk("arp_eop_drained", q_arp.size(), 0);
    end
  end

  task automatic set_busy(input logic ib, input logic ab);
    sif0.ip_busy  = ib;
    sif1.ip_busy  = ib;
    sif0.arp_busy = ab;
    sif1.arp_busy = ab;
  endtask

  task automatic drive_frame(input vec_t v, input int gap,
                             input int rst_at);
    logic [111:0] h;
    logic [7:0]   b;
    bit           live;
    h    = {v.dest, v.src, v.etype};
    live = 1'b1;
    for (int i = 0; i < v.len; i++) begin
      if (i < 14) b = h[111-8*i -: 8];
      else        b = 8'($urandom_range(255));
      datain  = b;
      data_en = 1'b1;
      set_busy(i >= v.ib_lo && i < v.ib_hi,
               i >= v.ab_lo && i < v.ab_hi);
      if (live && i >= 14 && v.exp == 0)
        q_ip.push_back({i == 14, b});
      if (live && i >= 14 && v.exp == 1)
        q_arp.push_back({i == 14, b});
      if (i == rst_at) begin
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        live = 1'b0;
        q_ip.delete();
        q_arp.delete();
        m0_ip = 0; m0_arp = 0; m0_drop = 0;
        m1_ip = 0; m1_arp = 0; m1_drop = 0;
        pc0 = '0; pc1 = '0;
      end
      @(posedge clk); #1;
    end
    data_en = 1'b0;
    datain  = 8'h00;
    set_busy(1'b0, 1'b0);
    if (live) begin
      case (v.exp)
        0: begin m0_ip++; pc0 = v.src; e_ip_eop++; end
        1: begin m0_arp++; pc0 = v.src; e_arp_eop++; end
        default: m0_drop++;
      endcase
      case (v.expp)
        0: begin m1_ip++; pc1 = v.src; end
        1: begin m1_arp++; pc1 = v.src; end
        default: m1_drop++;
      endcase
    end
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic check_all(input string t);
    chk({t, "_cnt_ip"},   cnt_ip0,   m0_ip);
    chk({t, "_cnt_arp"},  cnt_arp0,  m0_arp);
    chk({t, "_cnt_drop"}, cnt_drop0, m0_drop);
    chk({t, "_pc_mac"},   pc_mac0,   pc0);
    chk({t, "_p_cnt_ip"},   cnt_ip1,   m1_ip);
    chk({t, "_p_cnt_arp"},  cnt_arp1,  m1_arp);
    chk({t, "_p_cnt_drop"}, cnt_drop1, m1_drop);
    chk({t, "_p_pc_mac"},   pc_mac1,   pc1);
    chk({t, "_ip_eops"},  ip_eops,  e_ip_eop);
    chk({t, "_arp_eops"}, arp_eops, e_arp_eop);
    chk({t, "_ip_q"},  q_ip.size(),  0);
    chk({t, "_arp_q"}, q_arp.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{BM, 48'h0A0000000001, 16'h0800, 60, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{BC, 48'h0A0000000002, 16'h0806, 42, 0, 0, 0, 0, 1, 1};
    tbl[2]  = '{BC, 48'h0A0000000003, 16'h0806, 42, 13, 21, 0, 0, 1, 1};
    tbl[3]  = '{BC, 48'h0A0000000004, 16'h0800, 60, 0, 0, 0, 0, 2, 0};
    tbl[4]  = '{OM, 48'h0A0000000005, 16'h0800, 60, 0, 0, 0, 0, 2, 0};
    tbl[5]  = '{BM, 48'h0A0000000006, 16'h86DD, 60, 0, 0, 0, 0, 2, 2};
    tbl[6]  = '{BM, 48'h0A0000000007, 16'h0800, 10, 0, 0, 0, 0, 2, 2};
    tbl[7]  = '{BC, 48'h0A0000000008, 16'h0806, 42, 0, 0, 13, 20, 2, 2};
    tbl[8]  = '{BM, 48'h0A0000000009, 16'h0800, 14, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{BM, 48'h0A000000000A, 16'h0800, 64, 14, 64, 0, 0, 0, 0};
    tbl[10] = '{BM, 48'h0A000000000B, 16'h0800, 60, 0, 0, 13, 20, 0, 0};

    set_busy(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check_all("reset");
    chk("reset_ip_en",   sif0.ip_en,   0);
    chk("reset_ip_data", sif0.ip_data, 0);
    chk("reset_arp_en",  sif0.arp_en,  0);
    chk("reset_ip_eop",  sif0.ip_eop,  0);

    for (int k = 0; k < 11; k++) begin
      drive_frame(tbl[k], 3, -1);
      check_all($sformatf("vec%0d", k));
    end

    drive_frame(tbl[0], 1, -1);
    drive_frame(tbl[1], 1, -1);
    drive_frame(tbl[9], 3, -1);
    check_all("b2b");

    drive_frame(tbl[0], 3, 30);
    check_all("midrst");
    drive_frame(tbl[1], 3, -1);
    check_all("postrst");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
